// File: rtl/rv32i_pkg.sv
`default_nettype none
// =============================================================================
// Module : rv32i_pkg
// Shared store encoding, UART register map, STATUS bit layout and TX FSM states.
// Rev    : 1.0
// =============================================================================
package rv32i_pkg;

    typedef enum logic [1:0] {
        MW_NONE = 2'b00,
        MW_BYTE = 2'b01,
        MW_HALF = 2'b10,
        MW_WORD = 2'b11
    } memwrite_e;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] OFF_RSVD    = 2'd3;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 4;
    localparam int ST_CNT_HI = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// =============================================================================
// Module : sync_fifo
// Single-clock FIFO with show-ahead head, wrapping pointers and a count register.
// Rev    : 1.0
// =============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            count    <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// =============================================================================
// Module : uart_tx_mmio
// Memory-mapped 8N1 UART transmitter with TX FIFO, W1C overflow flag and baud divisor.
// Rev    : 1.0
// =============================================================================
module uart_tx_mmio
    import rv32i_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          DEFAULT_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [1:0]  we,
    output logic [31:0] rd,
    output logic        sel,
    output logic        tx,
    output logic        irq
);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] RESET_DIV = 16'(DEFAULT_DIV);

    logic            w_wr, w_wr_tx, w_wr_status, w_wr_baud;
    logic [7:0]      w_fifo_dout;
    logic            w_fifo_full, w_fifo_empty;
    logic [CW-1:0]   w_fifo_count;
    logic [3:0]      w_cnt_sat;
    logic [31:0]     w_status;
    logic            w_bit_done, w_going_idle, w_pop, w_push_ok;
    logic            unused_bits;

    tx_state_e       r_state;
    logic [15:0]     r_baud, r_frame_div, r_cnt;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_idx;
    logic            r_ovf;

    assign sel         = (a[31:4] == BASE_ADDR[31:4]);
    assign w_wr        = sel && (we != MW_NONE);
    assign w_wr_tx     = w_wr && (a[3:2] == OFF_TXDATA);
    assign w_wr_status = w_wr && (a[3:2] == OFF_STATUS);
    assign w_wr_baud   = w_wr && (a[3:2] == OFF_BAUDDIV);
    assign unused_bits = ^{a[1:0], wd[31:16]};

    assign w_bit_done   = (r_cnt == r_frame_div - 16'd1);
    assign w_going_idle = (r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_done);
    assign w_pop        = w_going_idle && !w_fifo_empty;
    assign w_push_ok    = w_wr_tx && (!w_fifo_full || w_pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_wr_tx),
        .din   (wd[7:0]),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    generate
        if (CW > 4) begin : g_cnt_sat
            assign w_cnt_sat = (|w_fifo_count[CW-1:4]) ? 4'hF : w_fifo_count[3:0];
        end else begin : g_cnt_direct
            assign w_cnt_sat = 4'(w_fifo_count);
        end
    endgenerate

    always_comb begin
        w_status                      = '0;
        w_status[ST_FULL]             = w_fifo_full;
        w_status[ST_EMPTY]            = w_fifo_empty;
        w_status[ST_BUSY]             = (r_state != S_IDLE);
        w_status[ST_OVF]              = r_ovf;
        w_status[ST_CNT_HI:ST_CNT_LO] = w_cnt_sat;
    end

    always_comb begin
        rd = '0;
        if (sel) begin
            case (a[3:2])
                OFF_STATUS:  rd = w_status;
                OFF_BAUDDIV: rd = {16'h0000, r_baud};
                default:     rd = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baud <= RESET_DIV;
            r_ovf  <= 1'b0;
        end else begin
            if (w_wr_baud) r_baud <= (wd[15:0] == 16'h0000) ? 16'd1 : wd[15:0];
            if (w_wr_tx && w_fifo_full && !w_pop) r_ovf <= 1'b1;
            else if (w_wr_status && wd[ST_OVF])   r_ovf <= 1'b0;
        end
    end

    // irq looks ahead one edge so it rises on the same edge the line goes idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            tx          <= 1'b1;
            irq         <= 1'b1;
            r_frame_div <= RESET_DIV;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
        end else begin
            irq <= w_going_idle && w_fifo_empty && !w_push_ok;
            if (r_state != S_IDLE) r_cnt <= w_bit_done ? 16'd0 : r_cnt + 16'd1;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state     <= S_START;
                        tx          <= 1'b0;
                        r_shift     <= w_fifo_dout;
                        r_frame_div <= r_baud;
                        r_cnt       <= '0;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_state   <= S_DATA;
                        tx        <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            tx      <= 1'b1;
                        end else begin
                            tx        <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        if (w_pop) begin
                            r_state     <= S_START;
                            tx          <= 1'b0;
                            r_shift     <= w_fifo_dout;
                            r_frame_div <= r_baud;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// =============================================================================
// Module : tb_uart_tx_mmio
// Directed register-table and serial-frame checks for uart_tx_mmio.
// Rev    : 1.0
// =============================================================================
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          NV   = 17;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, wd, rd;
    logic [1:0]  we;
    logic        sel, tx, irq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  we;
        logic        sel;
        logic [31:0] rd;
    } vec_t;

    vec_t vec [NV];

    uart_tx_mmio #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .wd  (wd),
        .we  (we),
        .rd  (rd),
        .sel (sel),
        .tx  (tx),
        .irq (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] w);
        @(negedge clk);
        a  = addr;
        wd = data;
        we = w;
        @(posedge clk);
        #1;
        we = 2'b00;
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        a = addr;
        #1;
        check(name, rd, exp);
    endtask

    // Called one step after the edge that raised the start bit.
    task automatic expect_frame(input string name, input logic [7:0] b, input int div);
        for (int k = 0; k < 10 * div; k++) begin
            int   bi;
            logic e;
            bi = k / div;
            if (bi == 0)      e = 1'b0;
            else if (bi <= 8) e = b[bi-1];
            else              e = 1'b1;
            check($sformatf("%s_c%0d", name, k), {31'b0, tx}, {31'b0, e});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        vec[0]  = '{BASE + 32'h4,  32'h0,         2'b00, 1'b1, 32'h2};
        vec[1]  = '{BASE + 32'h8,  32'h0,         2'b00, 1'b1, 32'd16};
        vec[2]  = '{BASE + 32'hC,  32'h0,         2'b00, 1'b1, 32'h0};
        vec[3]  = '{BASE + 32'h0,  32'h0,         2'b00, 1'b1, 32'h0};
        vec[4]  = '{BASE + 32'h20, 32'h0,         2'b00, 1'b0, 32'h0};
        vec[5]  = '{BASE + 32'h8,  32'hABCD_1234, 2'b11, 1'b1, 32'd16};
        vec[6]  = '{BASE + 32'h8,  32'h0,         2'b00, 1'b1, 32'h1234};
        vec[7]  = '{BASE + 32'h8,  32'hFFFF_0000, 2'b01, 1'b1, 32'h1234};
        vec[8]  = '{BASE + 32'h8,  32'h0,         2'b00, 1'b1, 32'h1};
        vec[9]  = '{BASE + 32'hC,  32'hFF,        2'b11, 1'b1, 32'h0};
        vec[10] = '{BASE + 32'hC,  32'h0,         2'b00, 1'b1, 32'h0};
        vec[11] = '{BASE + 32'h20, 32'h55,        2'b11, 1'b0, 32'h0};
        vec[12] = '{BASE + 32'h4,  32'h0,         2'b00, 1'b1, 32'h2};
        vec[13] = '{BASE + 32'h4,  32'hFFFF_FFFF, 2'b11, 1'b1, 32'h2};
        vec[14] = '{BASE + 32'h4,  32'h0,         2'b00, 1'b1, 32'h2};
        vec[15] = '{BASE + 32'h8,  32'h10,        2'b10, 1'b1, 32'h1};
        vec[16] = '{BASE + 32'h8,  32'h0,         2'b00, 1'b1, 32'd16};

        rst = 1'b0;
        a   = 32'h0;
        wd  = 32'h0;
        we  = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx", {31'b0, tx}, 32'h1);
        check("rst_irq", {31'b0, irq}, 32'h1);
        read_check("rst_status", BASE + 32'h4, 32'h2);
        @(negedge clk);
        rst = 1'b1;

        // Register map: rd is sampled before the edge that commits each write.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a  = vec[i].addr;
            wd = vec[i].wd;
            we = vec[i].we;
            #1;
            check($sformatf("vec%0d_sel", i), {31'b0, sel}, {31'b0, vec[i].sel});
            check($sformatf("vec%0d_rd", i), rd, vec[i].rd);
            @(posedge clk);
            #1;
            we = 2'b00;
        end

        // Single 0x55 frame at the default divisor.
        store(BASE, 32'h0000_0055, 2'b11);
        check("a_tx_e0", {31'b0, tx}, 32'h1);
        check("a_irq_e0", {31'b0, irq}, 32'h0);
        read_check("a_status_e0", BASE + 32'h4, 32'h10);
        @(posedge clk);
        #1;
        check("a_irq_run", {31'b0, irq}, 32'h0);
        read_check("a_status_run", BASE + 32'h4, 32'h6);
        expect_frame("a_frame", 8'h55, 16);
        check("a_irq_end", {31'b0, irq}, 32'h1);
        check("a_tx_end", {31'b0, tx}, 32'h1);

        // Divisor 0 is stored as 1.
        store(BASE + 32'h8, 32'h0, 2'b11);
        read_check("b_div0", BASE + 32'h8, 32'h1);
        store(BASE, 32'h0000_00C3, 2'b01);
        @(posedge clk);
        #1;
        expect_frame("b_frame", 8'hC3, 1);
        check("b_irq_end", {31'b0, irq}, 32'h1);

        // Divisor written on the pop edge only affects the following frame.
        store(BASE + 32'h8, 32'h3, 2'b11);
        store(BASE, 32'h81, 2'b01);
        store(BASE + 32'h8, 32'h1, 2'b11);
        expect_frame("m_old_div", 8'h81, 3);
        check("m_irq_end", {31'b0, irq}, 32'h1);
        store(BASE, 32'h7E, 2'b01);
        @(posedge clk);
        #1;
        expect_frame("m_new_div", 8'h7E, 1);

        // Back-to-back frames with no idle gap.
        store(BASE + 32'h8, 32'h4, 2'b11);
        store(BASE, 32'hA5, 2'b01);
        store(BASE, 32'h3C, 2'b01);
        expect_frame("c_first", 8'hA5, 4);
        expect_frame("c_second", 8'h3C, 4);
        check("c_irq_end", {31'b0, irq}, 32'h1);

        // Stalled transmitter: fill, overflow, W1C.
        store(BASE + 32'h8, 32'hFFFF, 2'b11);
        store(BASE, 32'h11, 2'b01);
        for (int i = 0; i < 8; i++) store(BASE, 32'h20 + i, 2'b01);
        read_check("d_full", BASE + 32'h4, 32'h85);
        store(BASE, 32'hEE, 2'b01);
        read_check("d_ovf", BASE + 32'h4, 32'h8D);
        store(BASE + 32'h4, 32'h7, 2'b11);
        read_check("d_w1c_nobit", BASE + 32'h4, 32'h8D);
        store(BASE + 32'h4, 32'h8, 2'b11);
        read_check("d_w1c", BASE + 32'h4, 32'h85);
        check("d_tx_start", {31'b0, tx}, 32'h0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("d_rst_tx", {31'b0, tx}, 32'h1);
        check("d_rst_status", rd, 32'h2);
        @(negedge clk);
        rst = 1'b1;
        read_check("d_rst_div", BASE + 32'h8, 32'd16);

        // Asynchronous reset in the middle of the data bits.
        store(BASE + 32'h8, 32'h4, 2'b11);
        store(BASE, 32'hF0, 2'b01);
        repeat (7) @(posedge clk);
        #1;
        check("e_tx_data", {31'b0, tx}, 32'h0);
        read_check("e_status_busy", BASE + 32'h4, 32'h6);
        #2;
        rst = 1'b0;
        #1;
        check("e_rst_tx", {31'b0, tx}, 32'h1);
        check("e_rst_status", rd, 32'h2);
        check("e_rst_irq", {31'b0, irq}, 32'h1);
        @(negedge clk);
        rst  = 1'b1;
        lows = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) lows++;
        end
        check("e_no_resume", lows, 0);
        read_check("e_div_default", BASE + 32'h8, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
